// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by an on-chip register-array memory.
// Independent read and write engines; INCR/FIXED/WRAP bursts, byte strobes, SLVERR on bad requests.
module axi4_sram_slave #(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       ID_W      = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       MEM_BYTES = 65536,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                clock,
  input  logic                reset,
  output logic                io_axi4_0_aw_ready,
  input  logic                io_axi4_0_aw_valid,
  input  logic [ID_W-1:0]     io_axi4_0_aw_id,
  input  logic [ADDR_W-1:0]   io_axi4_0_aw_addr,
  input  logic [7:0]          io_axi4_0_aw_len,
  input  logic [2:0]          io_axi4_0_aw_size,
  input  logic [1:0]          io_axi4_0_aw_burst,
  output logic                io_axi4_0_w_ready,
  input  logic                io_axi4_0_w_valid,
  input  logic [DATA_W-1:0]   io_axi4_0_w_data,
  input  logic [DATA_W/8-1:0] io_axi4_0_w_strb,
  input  logic                io_axi4_0_w_last,
  input  logic                io_axi4_0_b_ready,
  output logic                io_axi4_0_b_valid,
  output logic [ID_W-1:0]     io_axi4_0_b_id,
  output logic [1:0]          io_axi4_0_b_resp,
  output logic                io_axi4_0_ar_ready,
  input  logic                io_axi4_0_ar_valid,
  input  logic [ID_W-1:0]     io_axi4_0_ar_id,
  input  logic [ADDR_W-1:0]   io_axi4_0_ar_addr,
  input  logic [7:0]          io_axi4_0_ar_len,
  input  logic [2:0]          io_axi4_0_ar_size,
  input  logic [1:0]          io_axi4_0_ar_burst,
  input  logic                io_axi4_0_r_ready,
  output logic                io_axi4_0_r_valid,
  output logic [ID_W-1:0]     io_axi4_0_r_id,
  output logic [DATA_W-1:0]   io_axi4_0_r_data,
  output logic [1:0]          io_axi4_0_r_resp,
  output logic                io_axi4_0_r_last
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned MEM_AW = $clog2(MEM_BYTES);
  localparam int unsigned IDX_W  = MEM_AW - LSB;
  localparam int unsigned WORDS  = MEM_BYTES / STRB_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic logic [ADDR_W-1:0] mem_off(input logic [ADDR_W-1:0] a);
    return a - BASE_ADDR;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return mem_off(a) < ADDR_W'(MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(mem_off(a) >> LSB);
  endfunction

  function automatic logic wrap_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Illegal WRAP lengths and the reserved encoding degrade to INCR.
  function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
    if (burst == 2'b10 && wrap_ok(len)) return 2'b10;
    else if (burst == 2'b00)            return 2'b00;
    else                                return 2'b01;
  endfunction

  function automatic logic size_err(input logic [2:0] size);
    return 32'(size) > LSB;
  endfunction

  function automatic logic req_err(input logic [2:0] size, input logic [7:0] len,
                                   input logic [1:0] burst);
    return size_err(size) || (burst == 2'b11) || (burst == 2'b10 && !wrap_ok(len));
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] size,
                                                  input logic [7:0] len,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] step, al, inc, win;
    step = ADDR_W'(1) << size;
    al   = a & ~(step - ADDR_W'(1));
    inc  = al + step;
    win  = (ADDR_W'(len) + ADDR_W'(1)) << size;
    case (burst)
      2'b00:   return a;
      2'b10:   return (al & ~(win - ADDR_W'(1))) | (inc & (win - ADDR_W'(1)));
      default: return inc;
    endcase
  endfunction

  logic [DATA_W-1:0] mem [WORDS];

  // Write engine
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d;
  logic              wsz_err_q, wsz_err_d, werr_q, werr_d;
  logic              w_beat_last, mem_we;
  logic [IDX_W-1:0]  mem_widx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (io_axi4_0_aw_valid)               w_state_d = W_DATA;
      W_DATA:  if (io_axi4_0_w_valid && w_beat_last) w_state_d = W_RESP;
      W_RESP:  if (io_axi4_0_b_ready)                w_state_d = W_IDLE;
      default:                                       w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    io_axi4_0_aw_ready = (w_state_q == W_IDLE);
    io_axi4_0_w_ready  = (w_state_q == W_DATA);
    io_axi4_0_b_valid  = (w_state_q == W_RESP);
    io_axi4_0_b_id     = (w_state_q == W_RESP) ? wid_q : '0;
    io_axi4_0_b_resp   = (w_state_q == W_RESP && werr_q) ? 2'b10 : 2'b00;
  end

  always_comb begin
    wid_d       = wid_q;
    waddr_d     = waddr_q;
    wlen_d      = wlen_q;
    wcnt_d      = wcnt_q;
    wsize_d     = wsize_q;
    wburst_d    = wburst_q;
    wsz_err_d   = wsz_err_q;
    werr_d      = werr_q;
    mem_we      = 1'b0;
    mem_widx    = word_idx(waddr_q);
    w_beat_last = (wcnt_q == wlen_q);
    if (w_state_q == W_IDLE && io_axi4_0_aw_valid) begin
      wid_d     = io_axi4_0_aw_id;
      waddr_d   = io_axi4_0_aw_addr;
      wlen_d    = io_axi4_0_aw_len;
      wcnt_d    = '0;
      wsize_d   = io_axi4_0_aw_size;
      wburst_d  = eff_burst(io_axi4_0_aw_burst, io_axi4_0_aw_len);
      wsz_err_d = size_err(io_axi4_0_aw_size);
      werr_d    = req_err(io_axi4_0_aw_size, io_axi4_0_aw_len, io_axi4_0_aw_burst);
    end else if (w_state_q == W_DATA && io_axi4_0_w_valid) begin
      mem_we  = !wsz_err_q && in_range(waddr_q);
      werr_d  = werr_q || !in_range(waddr_q) || (io_axi4_0_w_last != w_beat_last);
      waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
      wcnt_d  = wcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wsz_err_q <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wsz_err_q <= wsz_err_d;
      werr_q    <= werr_d;
    end
  end

  // Memory is deliberately left out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (io_axi4_0_w_strb[i]) mem[mem_widx][8*i +: 8] <= io_axi4_0_w_data[8*i +: 8];
      end
    end
  end

  // Read engine
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d, r_nxt;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d, rresp_q, rresp_d;
  logic              rreq_err_q, rreq_err_d, rlast_q, rlast_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (io_axi4_0_ar_valid)               r_state_d = R_DATA;
      R_DATA:  if (io_axi4_0_r_ready && rlast_q)     r_state_d = R_IDLE;
      default:                                       r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    io_axi4_0_ar_ready = (r_state_q == R_IDLE);
    io_axi4_0_r_valid  = (r_state_q == R_DATA);
    io_axi4_0_r_id     = rid_q;
    io_axi4_0_r_data   = rdata_q;
    io_axi4_0_r_resp   = rresp_q;
    io_axi4_0_r_last   = rlast_q;
  end

  // Data for the next beat is fetched on the same edge as the current beat's handshake.
  always_comb begin
    rid_d      = rid_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rcnt_d     = rcnt_q;
    rsize_d    = rsize_q;
    rburst_d   = rburst_q;
    rreq_err_d = rreq_err_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    r_nxt      = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
    if (r_state_q == R_IDLE && io_axi4_0_ar_valid) begin
      rid_d      = io_axi4_0_ar_id;
      raddr_d    = io_axi4_0_ar_addr;
      rlen_d     = io_axi4_0_ar_len;
      rcnt_d     = '0;
      rsize_d    = io_axi4_0_ar_size;
      rburst_d   = eff_burst(io_axi4_0_ar_burst, io_axi4_0_ar_len);
      rreq_err_d = req_err(io_axi4_0_ar_size, io_axi4_0_ar_len, io_axi4_0_ar_burst);
      rdata_d    = in_range(io_axi4_0_ar_addr) ? mem[word_idx(io_axi4_0_ar_addr)] : '0;
      rresp_d    = (rreq_err_d || !in_range(io_axi4_0_ar_addr)) ? 2'b10 : 2'b00;
      rlast_d    = (io_axi4_0_ar_len == 8'd0);
    end else if (r_state_q == R_DATA && io_axi4_0_r_ready) begin
      if (rlast_q) begin
        rlast_d = 1'b0;
      end else begin
        raddr_d = r_nxt;
        rcnt_d  = rcnt_q + 8'd1;
        rdata_d = in_range(r_nxt) ? mem[word_idx(r_nxt)] : '0;
        rresp_d = (rreq_err_q || !in_range(r_nxt)) ? 2'b10 : 2'b00;
        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rid_q      <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rcnt_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
      rreq_err_q <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
    end else begin
      rid_q      <= rid_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rcnt_q     <= rcnt_d;
      rsize_q    <= rsize_d;
      rburst_q   <= rburst_d;
      rreq_err_q <= rreq_err_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Self-checking bench for axi4_sram_slave: directed steps plus randomized bursts against a byte-array model.
module tb_axi4_sram_slave;
  localparam int          DW   = 64;
  localparam int          IW   = 4;
  localparam int          AW   = 32;
  localparam int          MB   = 65536;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          aw_ready, aw_valid = 0, w_ready, w_valid = 0, w_last = 0;
  logic          b_ready = 0, b_valid, ar_ready, ar_valid = 0, r_ready = 0, r_valid, r_last;
  logic [IW-1:0] aw_id = 0, b_id, ar_id = 0, r_id;
  logic [AW-1:0] aw_addr = 0, ar_addr = 0;
  logic [7:0]    aw_len = 0, ar_len = 0, w_strb = 0;
  logic [2:0]    aw_size = 0, ar_size = 0;
  logic [1:0]    aw_burst = 0, ar_burst = 0, b_resp, r_resp;
  logic [DW-1:0] w_data = 0, r_data;

  axi4_sram_slave #(.DATA_W(DW), .ID_W(IW), .ADDR_W(AW), .MEM_BYTES(MB), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset),
    .io_axi4_0_aw_ready(aw_ready), .io_axi4_0_aw_valid(aw_valid), .io_axi4_0_aw_id(aw_id),
    .io_axi4_0_aw_addr(aw_addr), .io_axi4_0_aw_len(aw_len), .io_axi4_0_aw_size(aw_size),
    .io_axi4_0_aw_burst(aw_burst),
    .io_axi4_0_w_ready(w_ready), .io_axi4_0_w_valid(w_valid), .io_axi4_0_w_data(w_data),
    .io_axi4_0_w_strb(w_strb), .io_axi4_0_w_last(w_last),
    .io_axi4_0_b_ready(b_ready), .io_axi4_0_b_valid(b_valid), .io_axi4_0_b_id(b_id),
    .io_axi4_0_b_resp(b_resp),
    .io_axi4_0_ar_ready(ar_ready), .io_axi4_0_ar_valid(ar_valid), .io_axi4_0_ar_id(ar_id),
    .io_axi4_0_ar_addr(ar_addr), .io_axi4_0_ar_len(ar_len), .io_axi4_0_ar_size(ar_size),
    .io_axi4_0_ar_burst(ar_burst),
    .io_axi4_0_r_ready(r_ready), .io_axi4_0_r_valid(r_valid), .io_axi4_0_r_id(r_id),
    .io_axi4_0_r_data(r_data), .io_axi4_0_r_resp(r_resp), .io_axi4_0_r_last(r_last)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0]  model [MB];
  logic [63:0] wd [$];
  logic [7:0]  ws [$];
  logic [63:0] rd_data [$];
  logic [1:0]  rd_resp [$];
  logic        rd_last [$];
  logic [3:0]  rd_id [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic wrap_legal(input logic [7:0] len);
    return len == 1 || len == 3 || len == 7 || len == 15;
  endfunction

  // Address of beat k computed directly from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst, input int k);
    logic [31:0] step, al, win, base;
    step = 32'd1 << size;
    if (burst == 2'b00 || k == 0) return start;
    al = start & ~(step - 1);
    if (burst == 2'b10 && wrap_legal(len)) begin
      win  = (32'(len) + 1) * step;
      base = al - (al % win);
      return base + ((al - base + 32'(k) * step) % win);
    end
    return al + 32'(k) * step;
  endfunction

  function automatic logic beat_err(input logic [31:0] start, input logic [2:0] size,
                                    input logic [7:0] len, input logic [1:0] burst, input int k);
    logic [31:0] a;
    a = beat_addr(start, size, len, burst, k);
    return size > 3 || burst == 2'b11 || (burst == 2'b10 && !wrap_legal(len)) ||
           (a - BASE) >= 32'(MB);
  endfunction

  function automatic logic [63:0] model_word(input logic [31:0] a);
    logic [31:0] off;
    logic [63:0] w;
    off = a - BASE;
    if (off >= 32'(MB)) return 64'd0;
    off = off & ~32'd7;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = model[off + 32'(i)];
    return w;
  endfunction

  task automatic model_write(input logic [31:0] start, input logic [2:0] size,
                             input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] off;
    for (int k = 0; k <= int'(len); k++) begin
      off = beat_addr(start, size, len, burst, k) - BASE;
      if (size <= 3 && off < 32'(MB))
        for (int i = 0; i < 8; i++)
          if (ws[k][i]) model[(off & ~32'd7) + 32'(i)] = wd[k][8*i +: 8];
    end
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, output int waits);
    logic hs = 0;
    aw_valid = 1; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id;
    waits = 0;
    while (!hs && waits < 50) begin
      @(negedge clock); hs = aw_ready; waits++;
      @(posedge clock); #1;
    end
    aw_valid = 0;
    chk("aw_handshake", 64'(hs), 64'd1);
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
    logic hs = 0;
    int n = 0;
    w_valid = 1; w_data = data; w_strb = strb; w_last = last;
    while (!hs && n < 50) begin
      @(negedge clock); hs = w_ready; n++;
      @(posedge clock); #1;
    end
    w_valid = 0; w_last = 0;
    chk("w_handshake", 64'(hs), 64'd1);
  endtask

  task automatic b_get(input int stall, output logic [1:0] resp, output logic [3:0] id);
    logic seen = 0;
    int n = 0;
    logic [1:0] sr;
    logic [3:0] si;
    while (!seen && n < 100) begin
      @(negedge clock); seen = b_valid; n++;
    end
    chk("b_valid_seen", 64'(seen), 64'd1);
    sr = b_resp; si = b_id;
    repeat (stall) begin
      @(negedge clock);
      chk("b_hold_valid", 64'(b_valid), 64'd1);
      chk("b_hold_resp_id", {58'd0, b_resp, b_id}, {58'd0, sr, si});
    end
    resp = b_resp; id = b_id;
    b_ready = 1;
    @(posedge clock); #1;
    b_ready = 0;
    chk("b_valid_drop", 64'(b_valid), 64'd0);
  endtask

  task automatic check_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id, input int stall,
                             input logic bad_last);
    int waits;
    logic [1:0] resp;
    logic [3:0] bid;
    logic err = bad_last;
    aw_send(addr, len, size, burst, id, waits);
    for (int k = 0; k <= int'(len); k++) w_send(wd[k], ws[k], bad_last ? 1'b0 : (k == int'(len)));
    b_get(stall, resp, bid);
    for (int k = 0; k <= int'(len); k++) err |= beat_err(addr, size, len, burst, k);
    chk("b_resp", 64'(resp), err ? 64'd2 : 64'd0);
    chk("b_id", 64'(bid), 64'(id));
    model_write(addr, size, len, burst);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input int stall);
    logic hs = 0;
    int n = 0;
    int beat = 0;
    logic [63:0] sd;
    rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_id.delete();
    ar_valid = 1; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id;
    while (!hs && n < 50) begin
      @(negedge clock); hs = ar_ready; n++;
      @(posedge clock); #1;
    end
    ar_valid = 0;
    chk("ar_handshake", 64'(hs), 64'd1);
    r_ready = 1;
    n = 0;
    while (beat <= int'(len) && n < 2000) begin
      @(negedge clock); n++;
      if (r_valid) begin
        if (beat == 0) chk("r_first_latency", 64'(n), 64'd1);
        if (beat == 1 && stall > 0) begin
          r_ready = 0; sd = r_data;
          repeat (stall) begin
            @(negedge clock); n++;
            chk("r_hold_valid", 64'(r_valid), 64'd1);
            chk("r_hold_data", r_data, sd);
          end
          r_ready = 1;
        end
        rd_data.push_back(r_data); rd_resp.push_back(r_resp);
        rd_last.push_back(r_last); rd_id.push_back(r_id);
        beat++;
      end
    end
    chk("r_beat_count", 64'(beat), 64'(int'(len) + 1));
    @(posedge clock); #1;
    r_ready = 0;
    chk("r_valid_drop", 64'(r_valid), 64'd0);
  endtask

  task automatic check_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int stall);
    logic [31:0] a;
    do_read(addr, len, size, burst, id, stall);
    for (int k = 0; k < rd_data.size(); k++) begin
      a = beat_addr(addr, size, len, burst, k);
      chk("r_data", rd_data[k], model_word(a));
      chk("r_resp", 64'(rd_resp[k]), beat_err(addr, size, len, burst, k) ? 64'd2 : 64'd0);
      chk("r_last", 64'(rd_last[k]), 64'(k == int'(len)));
      chk("r_id", 64'(rd_id[k]), 64'(id));
    end
  endtask

  task automatic fill(input int beats, input logic [63:0] base_val, input logic rnd);
    wd.delete(); ws.delete();
    for (int k = 0; k < beats; k++) begin
      wd.push_back(rnd ? {$urandom, $urandom} : base_val + 64'(k) * 64'h11);
      ws.push_back(rnd ? 8'($urandom) : 8'hFF);
    end
  endtask

  initial begin
    int waits;
    logic [1:0] resp, burst;
    logic [3:0] bid;
    logic [7:0] len;
    logic [2:0] size;
    logic [31:0] addr;

    for (int i = 0; i < MB; i++) model[i] = 8'h00;
    #1 reset = 0;
    #2;
    chk("rst_aw_ready", 64'(aw_ready), 64'd1);
    chk("rst_ar_ready", 64'(ar_ready), 64'd1);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_valids", {61'd0, b_valid, r_valid, r_last}, 64'd0);
    chk("rst_payload", {54'd0, b_id, b_resp, r_id, r_resp}, 64'd0);
    chk("rst_r_data", r_data, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1;

    // Zero the region used below so the model starts in agreement with the memory.
    fill(64, 64'd0, 0);
    for (int k = 0; k < 64; k++) wd[k] = 64'd0;
    check_write(BASE, 8'd63, 3'd3, 2'b01, 4'd1, 0, 0);

    fill(4, 64'h11, 0);
    check_write(BASE, 8'd3, 3'd3, 2'b01, 4'd5, 0, 0);
    do_read(BASE, 8'd3, 3'd3, 2'b01, 4'd9, 0);
    chk("incr_d0", rd_data[0], 64'h11);
    chk("incr_d1", rd_data[1], 64'h22);
    chk("incr_d2", rd_data[2], 64'h33);
    chk("incr_d3", rd_data[3], 64'h44);
    chk("incr_last", {60'd0, rd_last[3], rd_last[2], rd_last[1], rd_last[0]}, 64'b1000);
    chk("incr_rid", 64'(rd_id[0]), 64'd9);

    fill(1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    check_write(BASE + 32'h100, 8'd0, 3'd3, 2'b01, 4'd2, 0, 0);
    wd[0] = 64'd0; ws[0] = 8'h0F;
    check_write(BASE + 32'h100, 8'd0, 3'd3, 2'b01, 4'd2, 0, 0);
    do_read(BASE + 32'h100, 8'd0, 3'd3, 2'b01, 4'd3, 0);
    chk("strobe_word", rd_data[0], 64'hFFFF_FFFF_0000_0000);

    fill(4, 64'hA0, 0);
    for (int k = 0; k < 4; k++) wd[k] = 64'hA0 + 64'(k);
    check_write(BASE, 8'd3, 3'd3, 2'b01, 4'd4, 0, 0);
    do_read(BASE + 32'h18, 8'd3, 3'd3, 2'b10, 4'd6, 0);
    chk("wrap_b0", rd_data[0], 64'hA3);
    chk("wrap_b1", rd_data[1], 64'hA0);
    chk("wrap_b2", rd_data[2], 64'hA1);
    chk("wrap_b3", rd_data[3], 64'hA2);
    do_read(BASE + 32'h18, 8'd2, 3'd3, 2'b10, 4'd6, 0);
    for (int k = 0; k < rd_resp.size(); k++) chk("wrap_bad_len_resp", 64'(rd_resp[k]), 64'd2);

    fill(1, 64'hDEAD_BEEF_0BAD_F00D, 0);
    check_write(BASE + 32'(MB), 8'd0, 3'd3, 2'b01, 4'd7, 0, 0);
    check_read(BASE, 8'd0, 3'd3, 2'b01, 4'd7, 0);
    do_read(BASE + 32'(MB), 8'd0, 3'd3, 2'b01, 4'd8, 0);
    chk("oor_r_data", rd_data[0], 64'd0);
    chk("oor_r_resp", 64'(rd_resp[0]), 64'd2);

    fill(2, 64'h5555, 0);
    check_write(BASE + 32'h1E0, 8'd1, 3'd3, 2'b01, 4'd10, 0, 1);
    fill(1, 64'h7777, 0);
    check_write(BASE + 32'h1F0, 8'd0, 3'd4, 2'b01, 4'd11, 0, 0);
    check_read(BASE + 32'h1F0, 8'd0, 3'd3, 2'b01, 4'd11, 0);

    for (int it = 0; it < 16; it++) begin
      burst = 2'($urandom_range(0, 2));
      size  = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: len = 8'd1;
        1: len = 8'd3;
        2: len = 8'd7;
        default: len = 8'd15;
      endcase
      if (burst != 2'b10) len = 8'($urandom_range(0, 7));
      addr = BASE + 32'($urandom_range(0, 32'hBF));
      fill(int'(len) + 1, 64'd0, 1);
      check_write(addr, len, size, burst, 4'($urandom), 0, 0);
      check_read(addr, len, size, burst, 4'($urandom), 0);
    end

    fill(8, 64'd0, 1);
    fork
      check_write(BASE + 32'h140, 8'd7, 3'd3, 2'b01, 4'd12, 5, 0);
      check_read(BASE + 32'h100, 8'd7, 3'd3, 2'b01, 4'd13, 5);
    join

    fill(4, 64'h99, 0);
    aw_send(BASE + 32'h180, 8'd3, 3'd3, 2'b01, 4'd14, waits);
    w_send(wd[0], ws[0], 1'b0);
    w_send(wd[1], ws[1], 1'b0);
    #2 reset = 0;
    #1;
    chk("mid_rst_aw_ready", 64'(aw_ready), 64'd1);
    chk("mid_rst_w_ready", 64'(w_ready), 64'd0);
    chk("mid_rst_valids", {61'd0, b_valid, r_valid, r_last}, 64'd0);
    chk("mid_rst_payload", {54'd0, b_id, b_resp, r_id, r_resp}, 64'd0);
    @(posedge clock); #1 reset = 1;
    fill(1, 64'h1234_5678_9ABC_DEF0, 0);
    aw_send(BASE + 32'h1C0, 8'd0, 3'd3, 2'b01, 4'd15, waits);
    chk("aw_wait_after_reset", 64'(waits), 64'd1);
    w_send(wd[0], ws[0], 1'b1);
    b_get(0, resp, bid);
    chk("post_rst_b_resp", 64'(resp), 64'd0);
    chk("post_rst_b_id", 64'(bid), 64'd15);
    model_write(BASE + 32'h1C0, 3'd3, 8'd0, 2'b01);
    check_read(BASE + 32'h1C0, 8'd0, 3'd3, 2'b01, 4'd2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
Parametrised AXI4 slave backed by an internal register-array memory. It replaces the tied-off AXI memory stub on the rocket-chip memory port so the core can run from on-chip RAM in simulation and on FPGA. It has independent read and write engines, INCR/FIXED/WRAP bursts, byte strobes, narrow transfers and error responses for out-of-range or unsupported requests.

Parameters:
DATA_W, 64, data bus width in bits; must be a power of 2, 32..256.
ID_W, 4, AXI ID width.
ADDR_W, 32, AXI address width.
MEM_BYTES, 65536, memory size in bytes; must be a power of 2 and a multiple of DATA_W/8.
BASE_ADDR, 32'h8000_0000, byte address that maps to memory offset 0.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
io_axi4_0_aw_ready/valid, aw_id[ID_W], aw_addr[ADDR_W], aw_len[8], aw_size[3], aw_burst[2]  AXI4 write address channel.
io_axi4_0_w_ready/valid, w_data[DATA_W], w_strb[DATA_W/8], w_last  AXI4 write data channel.
io_axi4_0_b_ready/valid, b_id[ID_W], b_resp[2]  AXI4 write response channel.
io_axi4_0_ar_ready/valid, ar_id[ID_W], ar_addr[ADDR_W], ar_len[8], ar_size[3], ar_burst[2]  AXI4 read address channel.
io_axi4_0_r_ready/valid, r_id[ID_W], r_data[DATA_W], r_resp[2], r_last  AXI4 read data channel.
Port directions follow the slave side: valid/payload in and ready out on AW/W/AR; valid/payload out and ready in on B/R.

Behaviour:
- Reset (reset=0, asynchronous): both FSMs go idle; aw_ready=1, ar_ready=1; w_ready=0, b_valid=0, r_valid=0, r_last=0; b_id/b_resp/r_id/r_data/r_resp=0. Memory contents are not cleared. Reset mid-burst abandons the burst with no response.
- Handshake: a transfer occurs when valid & ready are high at a clock edge. Outputs hold stable while valid is high and ready is low.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: aw_ready=1. An AW handshake latches id, addr, len, size and burst, clears the error flag, and moves to W_DATA.
  - W_DATA: w_ready=1, aw_ready=0. Each beat writes the strobed bytes at the current address, then advances the address.
  - The burst ends after len+1 beats. w_last is ignored for counting; if w_last disagrees with the count, the error flag is set.
  - W_RESP: b_valid=1 with b_id equal to the latched id. b_resp=2'b10 (SLVERR) if the error flag is set, else 2'b00. On b_ready, return to W_IDLE; aw_ready rises the following cycle.
- Read FSM: R_IDLE -> R_DATA.
  - R_IDLE: ar_ready=1. An AR handshake latches the request and moves to R_DATA.
  - r_valid rises the cycle after the AR handshake, with r_data registered from the first-beat address.
  - On each R handshake that is not the last beat, r_data is reloaded from the next address at the same edge, giving one beat per cycle under continuous r_ready.
  - r_last=1 on beat len. The handshake on that beat returns the FSM to R_IDLE.
  - r_resp is per beat: SLVERR if that beat errs, else OKAY.
- The read and write engines are fully independent. A read and a write to the same word in the same cycle returns the old data.
- Address arithmetic:
  - offset = addr - BASE_ADDR.
  - A beat is out of range if offset >= MEM_BYTES. Out-of-range beats write nothing, read as 0, and set SLVERR.
  - Word index = offset[log2(MEM_BYTES)-1 : log2(DATA_W/8)].
- Bursts:
  - FIXED (00): the address never changes.
  - INCR (01): addr += 1<<size; wraps modulo 2^ADDR_W.
  - WRAP (10): addr += 1<<size within the aligned window of (len+1)<<size bytes. Legal only for len in {1,3,7,15}; any other len gives SLVERR on every beat and the burst is treated as INCR.
  - Reserved (11): treated as INCR with SLVERR.
- Size and alignment:
  - size > log2(DATA_W/8) gives SLVERR on all beats; no memory write occurs.
  - Narrow writes use w_strb as given; lane selection is the master's responsibility.
  - Reads always return the full word.
  - Unaligned start addresses are accepted. Only the first beat is unaligned; later beats are aligned to size.
- Burst length: len up to 255 is supported; the beat counter is 8 bits.

Test Plan:
- INCR write then read: AW addr=0x8000_0000, len=3, size=3, data 0x11..0x44, strb=0xFF -> b_resp=0 and b_id echoed. AR with the same parameters -> 4 beats 0x11,0x22,0x33,0x44, r_last only on beat 4, first r_valid 1 cycle after the AR handshake.
- Strobes: write 0xFFFF_FFFF_FFFF_FFFF to 0x8000_0100, then write 0 with strb=0x0F -> read returns 0xFFFF_FFFF_0000_0000.
- WRAP: AR addr=0x8000_0018, len=3, size=3, burst=2 -> beat addresses 0x18, 0x00, 0x08, 0x10. A separate WRAP with len=2 -> every r_resp=2'b10.
- Out of range: write to BASE_ADDR+MEM_BYTES -> b_resp=2'b10 and memory unchanged. Read of the same address -> r_data=0, r_resp=2'b10.
- Backpressure and concurrency: hold r_ready and b_ready low for 5 cycles during simultaneous 8-beat read and write bursts -> r_valid/r_data and b_valid stay stable with no beat lost or duplicated. Both bursts then complete independently.
- Reset mid-burst: drive reset=0 after 2 of 4 W beats -> outputs at their reset values immediately. After release, a new AW is accepted at once with aw_ready=1.
